// File: rtl/alu8_pkg.sv
// Shared types and constants for the 8-bit add/subtract unit.
package alu8_pkg;

    localparam int unsigned DATA_W = 8;

    // Registered condition flags consumed by the control unit for conditional jumps.
    typedef struct packed {
        logic carry;
        logic is_zero;
    } flags_t;

endpackage

// File: rtl/alu_flags_reg.sv
// Two-bit flags register with asynchronous clear and load enable.
module alu_flags_reg
    import alu8_pkg::*;
(
    input  logic   clk_i,
    input  logic   clr_i,
    input  logic   load_i,
    input  flags_t d_i,
    output flags_t q_o
);

    flags_t flags_d;
    flags_t flags_q;

    // Next state: load new flags only when enabled, otherwise hold.
    always_comb begin
        flags_d = flags_q;
        if (load_i) begin
            flags_d = d_i;
        end
    end

    // State register; clear takes priority over any clock edge.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign q_o = flags_q;

endmodule

// File: rtl/alu8.sv
// 8-bit add/subtract unit: combinational result gated onto the bus, registered carry/zero flags.
module alu8
    import alu8_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    input  logic              en,
    input  logic              clk,
    input  logic              clr,
    input  logic              flag_en,
    output logic [DATA_W-1:0] ans,
    output logic              carry,
    output logic              is_zero
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] result;
    flags_t            flags_new;
    flags_t            flags_cur;

    // Adder/subtractor: subtraction is a + ~b + 1, so carry-out means "no borrow".
    always_comb begin
        b_op      = sub ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
        result    = sum[DATA_W-1:0];
        flags_new = '{carry: sum[DATA_W], is_zero: (result == '0)};
    end

    // Bus output is driven low rather than tri-stated; the bus mux lives outside.
    always_comb begin
        ans = en ? result : '0;
    end

    alu_flags_reg u_flags (
        .clk_i  (clk),
        .clr_i  (clr),
        .load_i (flag_en),
        .d_i    (flags_new),
        .q_o    (flags_cur)
    );

    assign carry   = flags_cur.carry;
    assign is_zero = flags_cur.is_zero;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed test-plan steps plus randomized traffic vs. a reference model.
`timescale 1ns/1ps
module tb_alu8;

    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub = 1'b0;
    logic       en = 1'b0;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       flag_en = 1'b0;
    logic [7:0] ans;
    logic       carry;
    logic       is_zero;

    int checks = 0;
    int failures = 0;

    alu8 dut (
        .a       (a),
        .b       (b),
        .sub     (sub),
        .en      (en),
        .clk     (clk),
        .clr     (clr),
        .flag_en (flag_en),
        .ans     (ans),
        .carry   (carry),
        .is_zero (is_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned operands.
    function automatic int model_result(input int ia, input int ib, input bit isub);
        int r;
        if (isub) r = (ia - ib + 256) % 256;
        else      r = (ia + ib) % 256;
        return r;
    endfunction

    function automatic bit model_carry(input int ia, input int ib, input bit isub);
        if (isub) return ia >= ib;
        else      return (ia + ib) > 255;
    endfunction

    bit model_c = 1'b0;
    bit model_z = 1'b0;

    // Model of the flags register: clear is immediate, load samples inputs at the edge.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            model_c <= 1'b0;
            model_z <= 1'b0;
        end else if (flag_en) begin
            model_c <= model_carry(int'(a), int'(b), sub);
            model_z <= (model_result(int'(a), int'(b), sub) == 0);
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare on every falling edge, away from the active edge.
    always @(negedge clk) begin
        int exp_ans;
        exp_ans = en ? model_result(int'(a), int'(b), sub) : 0;
        chk("model_ans", {1'b0, ans}, exp_ans[8:0]);
        chk("model_carry", {8'b0, carry}, {8'b0, model_c});
        chk("model_zero", {8'b0, is_zero}, {8'b0, model_z});
    end

    task automatic set_in(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          input logic te, input logic tfe);
        a = ta;
        b = tb;
        sub = ts;
        en = te;
        flag_en = tfe;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 clr = 1'b1;
        #1;
        chk("reset_carry", {8'b0, carry}, 9'd0);
        chk("reset_zero", {8'b0, is_zero}, 9'd0);
        next_edge();
        clr = 1'b0;

        // 1: add
        set_in(8'd20, 8'd10, 1'b0, 1'b1, 1'b1);
        #1 chk("t1_ans", {1'b0, ans}, 9'd30);
        next_edge();
        chk("t1_carry", {8'b0, carry}, 9'd0);
        chk("t1_zero", {8'b0, is_zero}, 9'd0);
        en = 1'b0;
        #1 chk("t1_ans_dis", {1'b0, ans}, 9'd0);

        // 2: subtract, then borrow
        set_in(8'd20, 8'd10, 1'b1, 1'b1, 1'b1);
        #1 chk("t2_ans", {1'b0, ans}, 9'd10);
        next_edge();
        chk("t2_carry", {8'b0, carry}, 9'd1);
        chk("t2_zero", {8'b0, is_zero}, 9'd0);
        set_in(8'd10, 8'd20, 1'b1, 1'b1, 1'b1);
        #1 chk("t2_ans_neg", {1'b0, ans}, 9'd246);
        next_edge();
        chk("t2_borrow", {8'b0, carry}, 9'd0);

        // 3: zero result
        set_in(8'd20, 8'd20, 1'b1, 1'b1, 1'b1);
        #1 chk("t3_ans", {1'b0, ans}, 9'd0);
        next_edge();
        chk("t3_zero", {8'b0, is_zero}, 9'd1);
        chk("t3_carry", {8'b0, carry}, 9'd1);

        // 4: hold with flag_en low, then reload
        set_in(8'd127, 8'd127, 1'b0, 1'b1, 1'b0);
        #1 chk("t4_ans", {1'b0, ans}, 9'd254);
        next_edge();
        chk("t4_hold_c1", {8'b0, carry}, 9'd1);
        chk("t4_hold_z1", {8'b0, is_zero}, 9'd1);
        next_edge();
        chk("t4_hold_c2", {8'b0, carry}, 9'd1);
        chk("t4_hold_z2", {8'b0, is_zero}, 9'd1);
        flag_en = 1'b1;
        next_edge();
        chk("t4_load_c", {8'b0, carry}, 9'd0);
        chk("t4_load_z", {8'b0, is_zero}, 9'd0);

        // 5: async clear mid-cycle with flags set
        set_in(8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
        next_edge();
        chk("t5_pre_c", {8'b0, carry}, 9'd1);
        chk("t5_pre_z", {8'b0, is_zero}, 9'd1);
        #2 clr = 1'b1;
        #1;
        chk("t5_clr_c", {8'b0, carry}, 9'd0);
        chk("t5_clr_z", {8'b0, is_zero}, 9'd0);
        set_in(8'd5, 8'd3, 1'b0, 1'b1, 1'b1);
        #1 chk("t5_ans", {1'b0, ans}, 9'd8);
        next_edge();
        chk("t5_held_c", {8'b0, carry}, 9'd0);
        chk("t5_held_z", {8'b0, is_zero}, 9'd0);

        // 6: wrap, also the first load after clear release
        set_in(8'd255, 8'd1, 1'b0, 1'b1, 1'b1);
        #1 chk("t6_ans", {1'b0, ans}, 9'd0);
        clr = 1'b0;
        next_edge();
        chk("t6_carry", {8'b0, carry}, 9'd1);
        chk("t6_zero", {8'b0, is_zero}, 9'd1);

        // 0-1 boundary
        set_in(8'd0, 8'd1, 1'b1, 1'b1, 1'b1);
        #1 chk("b01_ans", {1'b0, ans}, 9'd255);
        next_edge();
        chk("b01_carry", {8'b0, carry}, 9'd0);
        chk("b01_zero", {8'b0, is_zero}, 9'd0);

        // Randomized traffic, checked by the negedge compare process.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
            set_in(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0));
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                #2 a = 8'($urandom_range(0, 255));
            end
            next_edge();
        end
        clr = 1'b0;
        next_edge();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
